// File: rtl/mix_freq_pkg.sv
// ---------------------------------------------------------------------------
// mix_freq_pkg
// Shared definitions for the mix_freq table loader:
//   - state_t   : loader FSM states
//   - CH_SHIFT, CH_W, IDX_W : layout of the register-bus address {ch, idx}
//   - pack_addr : builds a 16-bit register address from channel and index
// ---------------------------------------------------------------------------
package mix_freq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_SYNC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CH_SHIFT = 12;
    localparam int CH_W     = 4;
    localparam int IDX_W    = 12;
    localparam int ADDR_W   = 16;

    // Channel select lives in the top nibble, table index in the low 12 bits.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [CH_W-1:0]  ch,
                                                     input logic [IDX_W-1:0] idx);
        logic [ADDR_W-1:0] a;
        a                    = '0;
        a[CH_SHIFT +: CH_W]  = ch;
        a[IDX_W-1:0]         = idx;
        return a;
    endfunction

endpackage

// File: rtl/mix_freq_tbl_loader.sv
// ---------------------------------------------------------------------------
// mix_freq_tbl_loader
// Streams a sine/reference table from an upstream valid/ready word source
// into every channel's table RAM of mix_freq_mc over the register bus, then
// programs sin_length and raises resync long enough for the pcm_clk domain.
//
// Ports
//   clk_2          : register-bus clock (only clock)
//   rst            : synchronous, active-high reset
//   start          : one-cycle load request, honoured only when idle
//   tbl_len        : words per channel, sampled at start
//   tbl_valid/ready: upstream word handshake (tbl_ready only high in FETCH)
//   tbl_data       : upstream table word, channel-major order
//   reg_addr       : {ch[3:0], idx[11:0]}
//   reg_wr         : write strobe, held with addr/data until reg_ready
//   reg_writedata  : write data
//   reg_ready      : bus accepts the write on a clk_2 edge with reg_wr=1
//   sin_length     : programmed table length, (len-1)<<1
//   resync         : RSYNC_CYC-cycle pulse to the mixer
//   busy           : high whenever the FSM is not idle
//   done           : one-cycle completion pulse
//   err            : one-cycle pulse when start carries an illegal length
// ---------------------------------------------------------------------------
module mix_freq_tbl_loader
    import mix_freq_pkg::*;
#(
    parameter int CHANNEL   = 1,
    parameter int pcmaw     = 10,
    parameter int RSYNC_CYC = 2
) (
    input  logic              clk_2,
    input  logic              rst,
    input  logic              start,
    input  logic [pcmaw-1:0]  tbl_len,
    input  logic              tbl_valid,
    output logic              tbl_ready,
    input  logic [31:0]       tbl_data,
    output logic [15:0]       reg_addr,
    output logic              reg_wr,
    output logic [31:0]       reg_writedata,
    input  logic              reg_ready,
    output logic [pcmaw-1:0]  sin_length,
    output logic              resync,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One bit wider than the index so a full 2^12-word table length fits.
    localparam int               LEN_W   = IDX_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << (pcmaw - 1);
    localparam int               CNT_W   = $clog2(RSYNC_CYC + 1);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tbl_ready_q, tbl_ready_d;
    logic                reg_wr_q, reg_wr_d;
    logic [15:0]         reg_addr_q, reg_addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [pcmaw-1:0]    sin_q, sin_d;
    logic                resync_q, resync_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [LEN_W-1:0]    tbl_len_ext;
    logic [LEN_W-1:0]    len_m1;
    logic [LEN_W-1:0]    sin_full;
    logic                len_ok;
    logic                last_idx;
    logic                last_ch;

    assign tbl_len_ext = LEN_W'(tbl_len);
    assign len_ok      = (tbl_len_ext != '0) && (tbl_len_ext <= MAX_LEN);
    assign len_m1      = len_q - LEN_W'(1);
    assign sin_full    = len_m1 << 1;
    assign last_idx    = ({1'b0, idx_q} == len_m1);
    assign last_ch     = (ch_q == CH_W'(CHANNEL - 1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ch_d        = ch_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        tbl_ready_d = tbl_ready_q;
        reg_wr_d    = reg_wr_q;
        reg_addr_d  = reg_addr_q;
        wdata_d     = wdata_q;
        sin_d       = sin_q;
        resync_d    = resync_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d       = tbl_len_ext;
                        ch_d        = '0;
                        idx_d       = '0;
                        tbl_ready_d = 1'b1;
                        state_d     = ST_FETCH;
                    end else begin
                        err_d       = 1'b1;
                    end
                end
            end

            ST_FETCH: begin
                if (tbl_valid && tbl_ready_q) begin
                    wdata_d     = tbl_data;
                    reg_addr_d  = pack_addr(ch_q, idx_q);
                    reg_wr_d    = 1'b1;
                    tbl_ready_d = 1'b0;
                    state_d     = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Strobe, address and data stay frozen until the bus accepts.
                if (reg_ready) begin
                    reg_wr_d = 1'b0;
                    if (last_idx && last_ch) begin
                        sin_d   = sin_full[pcmaw-1:0];
                        cnt_d   = '0;
                        state_d = ST_SYNC;
                    end else begin
                        if (last_idx) begin
                            idx_d = '0;
                            ch_d  = ch_q + CH_W'(1);
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                        tbl_ready_d = 1'b1;
                        state_d     = ST_FETCH;
                    end
                end
            end

            ST_SYNC: begin
                // First SYNC cycle only exposes the new sin_length; resync
                // follows so the mixer samples a settled length.
                if (cnt_q < CNT_W'(RSYNC_CYC)) begin
                    resync_d = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    resync_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            ch_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            tbl_ready_q <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_addr_q  <= '0;
            wdata_q     <= '0;
            sin_q       <= '0;
            resync_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ch_q        <= ch_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            tbl_ready_q <= tbl_ready_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            sin_q       <= sin_d;
            resync_q    <= resync_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign tbl_ready     = tbl_ready_q;
    assign reg_wr        = reg_wr_q;
    assign reg_addr      = reg_addr_q;
    assign reg_writedata = wdata_q;
    assign sin_length    = sin_q;
    assign resync        = resync_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mix_freq_tbl_loader.sv
module tb_mix_freq_tbl_loader;

    localparam int CHANNEL   = 2;
    localparam int PCMAW     = 10;
    localparam int RSYNC_CYC = 2;

    logic              clk_2 = 1'b0;
    logic              rst;
    logic              start;
    logic [PCMAW-1:0]  tbl_len;
    logic              tbl_valid;
    logic              tbl_ready;
    logic [31:0]       tbl_data;
    logic [15:0]       reg_addr;
    logic              reg_wr;
    logic [31:0]       reg_writedata;
    logic              reg_ready;
    logic [PCMAW-1:0]  sin_length;
    logic              resync;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk_2 = ~clk_2;

    mix_freq_tbl_loader #(
        .CHANNEL   (CHANNEL),
        .pcmaw     (PCMAW),
        .RSYNC_CYC (RSYNC_CYC)
    ) dut (
        .clk_2         (clk_2),
        .rst           (rst),
        .start         (start),
        .tbl_len       (tbl_len),
        .tbl_valid     (tbl_valid),
        .tbl_ready     (tbl_ready),
        .tbl_data      (tbl_data),
        .reg_addr      (reg_addr),
        .reg_wr        (reg_wr),
        .reg_writedata (reg_writedata),
        .reg_ready     (reg_ready),
        .sin_length    (sin_length),
        .resync        (resync),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_load
    int          n_wr;
    logic [15:0] wr_addr [0:1023];
    logic [31:0] wr_data [0:1023];
    int          consumed, extra_consumed, done_cnt, err_cnt, resync_cyc;
    int          overlap, hold_err, addr1_cyc, busy_cyc;
    logic        busy_first, busy_at_done, busy_after, done_after, timeout;
    logic [PCMAW-1:0] sin_before_rs, sin_at_rs;

    // Drives one load: start pulse, upstream words (optional gap), bus
    // back-pressure on one chosen write, optional start pulse while busy.
    // Inputs change on negedge after the outputs are sampled.
    task automatic run_load(input int len, input int gap, input int stall_at,
                            input int stall_len, input int busy_start_at,
                            input logic [31:0] base);
        int total      = CHANNEL * len;
        int w          = 0;
        int gapcnt     = 0;
        int stall_left = stall_len;
        int cyc        = 0;
        logic finished = 1'b0;
        logic seen_done = 1'b0;
        logic prev_wr  = 1'b0;
        logic prev_acc = 1'b0;
        logic [PCMAW-1:0] prev_sin;
        logic [15:0] prev_addr = '0;
        logic [31:0] prev_data = '0;

        n_wr = 0; extra_consumed = 0; done_cnt = 0; err_cnt = 0; resync_cyc = 0;
        overlap = 0; hold_err = 0; addr1_cyc = 0; busy_cyc = 0;
        busy_first = 1'b0; busy_at_done = 1'b0; busy_after = 1'b1; done_after = 1'b1;
        sin_before_rs = '0; sin_at_rs = '0;

        @(negedge clk_2);
        start     = 1'b1;
        tbl_len   = PCMAW'(len);
        tbl_valid = 1'b0;
        reg_ready = 1'b1;
        prev_sin  = sin_length;

        while (!finished && cyc < 5000) begin
            @(negedge clk_2);
            cyc++;
            if (cyc == 1) busy_first = busy;
            if (busy) busy_cyc++;
            if (err) err_cnt++;
            if (tbl_ready && reg_wr) overlap++;
            if (prev_wr && !prev_acc &&
                !(reg_wr && reg_addr == prev_addr && reg_writedata == prev_data)) hold_err++;
            if (prev_wr && reg_wr && reg_addr != prev_addr) hold_err++;
            if (reg_wr && reg_addr == 16'h0001) addr1_cyc++;
            if (resync) begin
                if (resync_cyc == 0) begin
                    sin_before_rs = prev_sin;
                    sin_at_rs     = sin_length;
                end
                resync_cyc++;
            end
            if (seen_done) begin
                busy_after = busy;
                done_after = done;
                finished   = 1'b1;
            end else if (done) begin
                done_cnt++;
                busy_at_done = busy;
                seen_done    = 1'b1;
            end
            prev_sin = sin_length;

            start   = (cyc == busy_start_at);
            tbl_len = start ? '0 : PCMAW'(len + 5);
            if (w < total) begin
                tbl_valid = (gapcnt == 0);
                tbl_data  = base + 32'(w);
                if (!tbl_valid) gapcnt--;
            end else begin
                tbl_valid = 1'b1;
                tbl_data  = 32'hDEAD_BEEF;
            end
            if (tbl_valid && tbl_ready) begin
                if (w < total) begin
                    w++;
                    gapcnt = gap;
                end else begin
                    extra_consumed++;
                end
            end
            if (reg_wr && n_wr == stall_at && stall_left > 0) begin
                reg_ready = 1'b0;
                stall_left--;
            end else begin
                reg_ready = 1'b1;
            end
            prev_wr   = reg_wr;
            prev_acc  = reg_wr && reg_ready;
            prev_addr = reg_addr;
            prev_data = reg_writedata;
            if (reg_wr && reg_ready) begin
                if (n_wr < 1024) begin
                    wr_addr[n_wr] = reg_addr;
                    wr_data[n_wr] = reg_writedata;
                end
                n_wr++;
            end
        end
        start     = 1'b0;
        tbl_valid = 1'b0;
        reg_ready = 1'b1;
        timeout   = !finished;
        consumed  = w;
    endtask

    task automatic test_reset();
        logic [56+PCMAW-1:0] outs;
        rst = 1'b1; start = 1'b0; tbl_len = '0; tbl_valid = 1'b0;
        tbl_data = '0; reg_ready = 1'b0;
        repeat (3) @(negedge clk_2);
        outs = {tbl_ready, reg_wr, resync, busy, done, err, reg_addr, reg_writedata, sin_length};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", outs);
        end
        rst = 1'b0;
        @(negedge clk_2);
        outs = {tbl_ready, reg_wr, resync, busy, done, err, reg_addr, reg_writedata, sin_length};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL idle_after_reset got %h want 0", outs);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_addr [0:5];
        exp_addr = '{16'h0000, 16'h0001, 16'h0002, 16'h1000, 16'h1001, 16'h1002};
        run_load(3, 0, -1, 0, 0, 32'hA000_0000);
        checks++;
        if (timeout) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
        checks++;
        if (n_wr !== 6) begin errors++; $display("FAIL basic_nwr got %0d want 6", n_wr); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== 32'hA000_0000 + 32'(i)) begin
                errors++;
                $display("FAIL basic_write%0d got %h/%h want %h/%h", i, wr_addr[i], wr_data[i],
                         exp_addr[i], 32'hA000_0000 + 32'(i));
            end
        end
        checks++;
        if (sin_at_rs !== 10'd4 || sin_before_rs !== 10'd4) begin
            errors++;
            $display("FAIL basic_sin got %0d/%0d want 4/4", sin_before_rs, sin_at_rs);
        end
        checks++;
        if (resync_cyc !== 2) begin errors++; $display("FAIL basic_resync got %0d want 2", resync_cyc); end
        checks++;
        if (done_cnt !== 1 || done_after !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got %0d/%b want 1/0", done_cnt, done_after);
        end
        checks++;
        if (busy_first !== 1'b1 || busy_at_done !== 1'b1 || busy_after !== 1'b0 || busy_cyc !== 16) begin
            errors++;
            $display("FAIL basic_busy got %b%b%b/%0d want 110/16", busy_first, busy_at_done,
                     busy_after, busy_cyc);
        end
        checks++;
        if (consumed !== 6 || extra_consumed !== 0) begin
            errors++;
            $display("FAIL basic_consumed got %0d+%0d want 6+0", consumed, extra_consumed);
        end
    endtask

    task automatic test_backpressure();
        run_load(3, 0, 1, 3, 0, 32'hB000_0000);
        checks++;
        if (addr1_cyc !== 4) begin errors++; $display("FAIL bp_hold_cycles got %0d want 4", addr1_cyc); end
        checks++;
        if (hold_err !== 0) begin errors++; $display("FAIL bp_stable got %0d want 0", hold_err); end
        checks++;
        if (n_wr !== 6 || timeout) begin errors++; $display("FAIL bp_nwr got %0d want 6", n_wr); end
        checks++;
        if (wr_addr[1] !== 16'h0001 || wr_data[1] !== 32'hB000_0001 || wr_addr[5] !== 16'h1002) begin
            errors++;
            $display("FAIL bp_addr got %h/%h/%h want 0001/b0000001/1002", wr_addr[1], wr_data[1], wr_addr[5]);
        end
    endtask

    task automatic test_gapped();
        int bad = 0;
        run_load(3, 4, -1, 0, 0, 32'hC000_0000);
        checks++;
        if (overlap !== 0) begin errors++; $display("FAIL gap_overlap got %0d want 0", overlap); end
        checks++;
        if (n_wr !== 6 || timeout || done_cnt !== 1) begin
            errors++;
            $display("FAIL gap_nwr got %0d/%0d want 6/1", n_wr, done_cnt);
        end
        for (int i = 0; i < 6; i++)
            if (wr_addr[i] !== 16'(((i / 3) << 12) | (i % 3)) || wr_data[i] !== 32'hC000_0000 + 32'(i)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL gap_writes got %0d bad want 0", bad); end
    endtask

    task automatic test_max_len();
        int bad = 0;
        run_load(512, 0, -1, 0, 0, 32'h0000_0000);
        checks++;
        if (n_wr !== 1024 || timeout) begin errors++; $display("FAIL max_nwr got %0d want 1024", n_wr); end
        checks++;
        if (sin_length !== 10'd1022) begin
            errors++;
            $display("FAIL max_sin got %0d want 1022", sin_length);
        end
        checks++;
        if (wr_addr[1023] !== 16'h11FF) begin
            errors++;
            $display("FAIL max_last_addr got %h want 11ff", wr_addr[1023]);
        end
        for (int i = 0; i < 1024; i++)
            if (wr_addr[i] !== 16'(((i / 512) << 12) | (i % 512)) || wr_data[i] !== 32'(i)) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL max_writes got %0d bad want 0", bad); end
    endtask

    task automatic test_bad_len();
        int lens [0:1];
        int activity;
        lens = '{513, 0};
        for (int k = 0; k < 2; k++) begin
            activity = 0;
            @(negedge clk_2);
            start = 1'b1; tbl_len = PCMAW'(lens[k]); tbl_valid = 1'b1; tbl_data = 32'h5555_0000;
            @(negedge clk_2);
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL badlen%0d_err got err=%b busy=%b want 1/0", lens[k], err, busy);
            end
            @(negedge clk_2);
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL badlen%0d_pulse got %b want 0", lens[k], err); end
            repeat (4) begin
                if (reg_wr || busy || tbl_ready) activity++;
                @(negedge clk_2);
            end
            checks++;
            if (activity !== 0 || sin_length !== 10'd1022) begin
                errors++;
                $display("FAIL badlen%0d_quiet got act=%0d sin=%0d want 0/1022", lens[k], activity, sin_length);
            end
        end
        tbl_valid = 1'b0;
    endtask

    task automatic test_rst_mid();
        logic [56+PCMAW-1:0] outs;
        int activity = 0;
        @(negedge clk_2);
        start = 1'b1; tbl_len = 10'd3; tbl_valid = 1'b1; tbl_data = 32'h7777_0000; reg_ready = 1'b0;
        @(negedge clk_2);
        start = 1'b0;
        @(negedge clk_2);
        checks++;
        if (reg_wr !== 1'b1) begin errors++; $display("FAIL rst_mid_inwrite got %b want 1", reg_wr); end
        rst = 1'b1;
        @(negedge clk_2);
        rst = 1'b0;
        outs = {tbl_ready, reg_wr, resync, busy, done, err, reg_addr, reg_writedata, sin_length};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", outs); end
        reg_ready = 1'b1;
        repeat (5) begin
            @(negedge clk_2);
            if (reg_wr || busy || tbl_ready) activity++;
        end
        tbl_valid = 1'b0;
        checks++;
        if (activity !== 0) begin errors++; $display("FAIL rst_mid_quiet got %0d want 0", activity); end
        run_load(3, 0, -1, 0, 0, 32'hE000_0000);
        checks++;
        if (n_wr !== 6 || done_cnt !== 1 || timeout || wr_addr[0] !== 16'h0000 ||
            wr_data[0] !== 32'hE000_0000 || wr_addr[5] !== 16'h1002 || sin_length !== 10'd4) begin
            errors++;
            $display("FAIL rst_mid_fresh got n=%0d done=%0d a0=%h d0=%h a5=%h sin=%0d want 6/1/0000/e0000000/1002/4",
                     n_wr, done_cnt, wr_addr[0], wr_data[0], wr_addr[5], sin_length);
        end
    endtask

    task automatic test_start_busy();
        int activity = 0;
        run_load(3, 0, -1, 0, 5, 32'hF000_0000);
        checks++;
        if (err_cnt !== 0) begin errors++; $display("FAIL busy_start_err got %0d want 0", err_cnt); end
        checks++;
        if (done_cnt !== 1 || done_after !== 1'b0 || n_wr !== 6 || timeout) begin
            errors++;
            $display("FAIL busy_start_load got done=%0d n=%0d want 1/6", done_cnt, n_wr);
        end
        repeat (4) begin
            @(negedge clk_2);
            if (busy || reg_wr || done || err) activity++;
        end
        checks++;
        if (activity !== 0) begin errors++; $display("FAIL busy_start_idle got %0d want 0", activity); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_max_len();
        test_bad_len();
        test_rst_mid();
        test_start_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_freq_tbl_loader.md
Name: mix_freq_tbl_loader

Overview:
- Sequences configuration of mix_freq_mc over the shared register bus.
- Streams a sine/reference table in from an upstream word source and writes it word-by-word into every channel's table RAM, honouring reg_ready back-pressure.
- After the last write it programs sin_length, then issues a resync pulse wide enough for the pcm_clk domain to see.
- Replaces hand-driven register loops with one start-to-done hardware sequence.

Parameters:
CHANNEL, 1, number of mixer channels (1..16)
pcmaw, 10, table address width; max table length 2^(pcmaw-1) words (pcmaw <= 13)
RSYNC_CYC, 2, clk_2 cycles resync is held high (>= pcm_clk/clk_2 ratio)

Ports:
clk_2  in  1  register-bus clock; only clock of the block
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE
tbl_len  in  pcmaw  words per channel (k)
tbl_valid  in  1  upstream word valid
tbl_ready  out  1  upstream word accept
tbl_data  in  32  table word; channel-major order, CHANNEL*k words total
reg_addr  out  16  {ch[3:0], idx[11:0]}
reg_wr  out  1  register write strobe
reg_writedata  out  32  write data
reg_ready  in  1  bus accepts write when reg_wr=1 and reg_ready=1 at a clk_2 edge
sin_length  out  pcmaw  programmed length, (k-1)<<1
resync  out  1  resync pulse to mixer
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse, start rejected

Behaviour:
- Reset values:
  - State IDLE.
  - tbl_ready, reg_wr, resync, busy, done and err are 0.
  - reg_addr, reg_writedata and sin_length are 0.
  - Internal ch and idx are 0.
  - rst asserted mid-load aborts at once: no further reg_wr, sin_length returns to 0.
- IDLE:
  - start=1 and 1 <= tbl_len <= 2^(pcmaw-1): latch len=tbl_len, set ch=0, idx=0, go to FETCH. busy rises next cycle.
  - start=1 with tbl_len out of range: err=1 next cycle, stay in IDLE, sin_length unchanged.
- FETCH:
  - tbl_ready=1 (registered, asserted on state entry).
  - On tbl_valid & tbl_ready, in the same edge:
    - reg_writedata <= tbl_data, reg_addr <= {ch, idx}, reg_wr <= 1, tbl_ready <= 0.
    - Go to WRITE.
  - No tbl_valid: wait indefinitely.
- WRITE:
  - reg_wr, reg_addr and reg_writedata are held stable until reg_ready=1.
  - At the accepting edge reg_wr <= 0.
  - Last word (ch==CHANNEL-1 and idx==len-1): go to SYNC.
  - Otherwise:
    - idx==len-1: idx <= 0, ch <= ch+1.
    - Else idx <= idx+1.
    - Go to FETCH.
  - Throughput: 2 cycles/word minimum.
  - reg_wr is never high in two consecutive cycles for different addresses.
- SYNC:
  - On entry, sin_length <= (len-1)<<1, truncated to pcmaw bits.
  - resync=1 for exactly RSYNC_CYC cycles, starting the cycle after sin_length updates.
  - Then go to DONE.
- DONE:
  - done=1 for one cycle, busy still 1.
  - Next cycle IDLE, busy=0.
- start while busy is ignored; no err.
- tbl_len is sampled only at start; changes mid-load are ignored.
- sin_length holds its value across loads until the next successful SYNC or reset.
- Upstream words beyond CHANNEL*len are not consumed: tbl_ready stays 0 outside FETCH.

Decomposition:
- Shared package mix_freq_pkg:
  - state enum (IDLE, FETCH, WRITE, SYNC, DONE).
  - CH_SHIFT=12, CH_W=4, IDX_W=12.
  - reg_addr pack function {ch, idx}.
- RSYNC_CYC counter and all FSM logic stay in one module.
- No sub-module needed.

Test Plan:
- CHANNEL=2, len=3, words A0..A5, reg_ready=1, tbl_valid=1 -> writes at 0x0000, 0x0001, 0x0002, 0x1000, 0x1001, 0x1002 with data A0..A5 in order; sin_length=4; resync high 2 cycles; done one cycle; busy spans start+1 through done.
- reg_ready held 0 for 3 cycles on the 2nd write -> reg_wr, reg_addr=0x0001 and reg_writedata held constant 4 cycles; exactly 6 accepted writes total.
- tbl_valid gapped (1 word every 5 cycles) -> tbl_ready high only in FETCH; no reg_wr while waiting; same final addresses and data.
- pcmaw=10: tbl_len=512 -> sin_length=1022, last address {CHANNEL-1, 0x1FF}. tbl_len=513 or 0 -> err pulse, no reg_wr, sin_length unchanged.
- rst asserted mid-WRITE -> next cycle all outputs 0, state IDLE; a fresh start completes normally.
- start pulsed during busy -> ignored; no err, load count unchanged, one done only.
